// File: rtl/kf_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kf_pad_pkg
// Purpose  : Shared types and constants for the Kalman-filter pad bridge.
//            Holds the frame command and FSM state encodings, beat-count
//            helpers and the pad-width divisibility check.
// Revision : 1.0
// ============================================================================
package kf_pad_pkg;

  // Frame command carried on the header beat
  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_WR_ROM  = 2'b10,
    CMD_RD_DATA = 2'b11
  } kf_cmd_e;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_DATA = 3'd1,
    ST_RX_ROM  = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_TX_WAIT = 3'd4,
    ST_TX      = 3'd5
  } kf_state_e;

  // Default geometry of the bridge
  localparam int DEF_PAD_W  = 4;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_ROM_W  = 16;

  // Number of pad beats needed to move a payload of the given width
  function automatic int kf_beats(input int payload_w, input int pad_w);
    return payload_w / pad_w;
  endfunction

  function automatic int kf_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Pad width must split both the data word and the {addr, data} ROM word
  // into whole beats, otherwise the last beat would carry a partial nibble.
  function automatic bit kf_pad_w_ok(input int pad_w, input int data_w,
                                     input int addr_w, input int rom_w);
    if (pad_w <= 0) return 1'b0;
    return ((data_w % pad_w) == 0) && (((addr_w + rom_w) % pad_w) == 0);
  endfunction

  localparam int DEF_BD = kf_beats(DEF_DATA_W, DEF_PAD_W);
  localparam int DEF_BR = kf_beats(DEF_ADDR_W + DEF_ROM_W, DEF_PAD_W);
  localparam bit DEF_PAD_W_OK = kf_pad_w_ok(DEF_PAD_W, DEF_DATA_W, DEF_ADDR_W, DEF_ROM_W);

endpackage
`default_nettype wire

// File: rtl/kf_pad_shreg.sv
`default_nettype none
// ============================================================================
// Module   : kf_pad_shreg
// Purpose  : Beat shift register shared by the receive and transmit paths.
//            New beats enter at the top, the outgoing beat is the bottom SW
//            bits; a parallel load overrides a shift.
// Revision : 1.0
// ============================================================================
module kf_pad_shreg #(
  parameter int W  = 24,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [W-1:0]  load_val_i,
  input  logic          shift_i,
  input  logic [SW-1:0] din_i,
  output logic [W-1:0]  shr_o,
  output logic [SW-1:0] lo_o
);

  logic [W-1:0] sr_q;

  // Value the register takes on a shift; also used to capture the last beat
  generate
    if (W > SW) begin : g_wide
      assign shr_o = {din_i, sr_q[W-1:SW]};
    end else begin : g_narrow
      assign shr_o = din_i;
    end
  endgenerate

  assign lo_o = sr_q[SW-1:0];

  // Load has priority over shift so frame ends and snapshots win
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_val_i;
    end else if (shift_i) begin
      sr_q <= shr_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kf_pad_bridge.sv
`default_nettype none
// ============================================================================
// Module   : kf_pad_bridge
// Purpose  : Framed narrow-bus bridge between the pad ring and the Kalman
//            filter core. Receives write-data and ROM-write frames and
//            serves read-data frames over a PAD_W-bit handshaken bus.
// Revision : 1.0
// ============================================================================
module kf_pad_bridge
  import kf_pad_pkg::*;
#(
  parameter int PAD_W  = DEF_PAD_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ROM_W  = DEF_ROM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic [1:0]        ext_cmd,
  input  logic [PAD_W-1:0]  ext_din,
  output logic [PAD_W-1:0]  ext_dout,
  output logic              ext_dout_vld,
  input  logic              ext_abort,
  output logic [DATA_W-1:0] core_data_in,
  output logic              core_data_in_vld,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [ROM_W-1:0]  rom_wdata
);

  localparam int RP_W = ADDR_W + ROM_W;
  localparam int BD   = kf_beats(DATA_W, PAD_W);
  localparam int BR   = kf_beats(RP_W, PAD_W);
  localparam int SR_W = kf_max(DATA_W, RP_W);
  localparam int CW   = $clog2(kf_max(BD, BR) + 1);

  generate
    if (!kf_pad_w_ok(PAD_W, DATA_W, ADDR_W, ROM_W)) begin : g_pad_w_check
      $error("kf_pad_bridge: PAD_W must divide DATA_W and ADDR_W+ROM_W");
    end
  endgenerate

  kf_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] core_data_in_q;
  logic              core_data_in_vld_q;
  logic              rom_we_q;
  logic [ADDR_W-1:0] rom_waddr_q;
  logic [ROM_W-1:0]  rom_wdata_q;
  logic              ext_dout_vld_q;

  logic              w_beat;
  logic              w_rx_last;
  logic              w_tx_last;
  logic              w_snap;
  logic              w_sh_load;
  logic              w_sh_shift;
  logic [SR_W-1:0]   w_sh_load_val;
  logic [SR_W-1:0]   w_sh_shr;
  logic [PAD_W-1:0]  w_sh_din;
  logic [PAD_W-1:0]  w_sh_lo;
  logic [RP_W-1:0]   w_rom_word;

  // Ready is a pure state decode; forced low while reset is held
  assign ext_ready = !rst && ((state_q == ST_IDLE)    || (state_q == ST_RX_DATA) ||
                              (state_q == ST_RX_ROM)  || (state_q == ST_TX));
  assign w_beat    = ext_valid && ext_ready;

  assign w_rx_last = w_beat && (((state_q == ST_RX_DATA) && (cnt_q == CW'(BD - 1))) ||
                                ((state_q == ST_RX_ROM)  && (cnt_q == CW'(BR - 1))));
  assign w_tx_last = w_beat && (state_q == ST_TX) && (cnt_q == CW'(BD - 1));
  assign w_snap    = (state_q == ST_TX_WAIT) && core_ready && !ext_abort;

  // The shift register is kept at zero outside a transmit frame, so its low
  // beat can drive ext_dout directly and still read 0 when nothing is valid.
  // Frame ends and aborts therefore reload it with zero.
  assign w_sh_load     = ext_abort || w_rx_last || w_tx_last || w_snap;
  assign w_sh_load_val = w_snap ? SR_W'(core_data_out) : '0;
  assign w_sh_shift    = w_beat && (state_q != ST_IDLE);
  assign w_sh_din      = (state_q == ST_TX) ? '0 : ext_din;
  assign w_rom_word    = w_sh_shr[SR_W-1 -: RP_W];

  kf_pad_shreg #(
    .W  (SR_W),
    .SW (PAD_W)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_sh_load),
    .load_val_i (w_sh_load_val),
    .shift_i    (w_sh_shift),
    .din_i      (w_sh_din),
    .shr_o      (w_sh_shr),
    .lo_o       (w_sh_lo)
  );

  // Frame FSM, beat counter and registered core/ROM outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      cnt_q              <= '0;
      core_data_in_q     <= '0;
      core_data_in_vld_q <= 1'b0;
      rom_we_q           <= 1'b0;
      rom_waddr_q        <= '0;
      rom_wdata_q        <= '0;
      ext_dout_vld_q     <= 1'b0;
    end else begin
      core_data_in_vld_q <= 1'b0;
      rom_we_q           <= 1'b0;
      if (ext_abort) begin
        // Abort beats any beat acceptance, including the final one
        state_q        <= ST_IDLE;
        cnt_q          <= '0;
        ext_dout_vld_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (w_beat) begin
              cnt_q <= '0;
              unique case (kf_cmd_e'(ext_cmd))
                CMD_WR_DATA: state_q <= ST_RX_DATA;
                CMD_WR_ROM:  state_q <= ST_RX_ROM;
                CMD_RD_DATA: state_q <= ST_TX_WAIT;
                default:     state_q <= ST_IDLE;
              endcase
            end
          end
          ST_RX_DATA: begin
            if (w_rx_last) begin
              core_data_in_q     <= w_sh_shr[SR_W-1 -: DATA_W];
              core_data_in_vld_q <= 1'b1;
              cnt_q              <= '0;
              state_q            <= ST_COMMIT;
            end else if (w_beat) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_RX_ROM: begin
            if (w_rx_last) begin
              rom_waddr_q <= w_rom_word[RP_W-1 -: ADDR_W];
              rom_wdata_q <= w_rom_word[ROM_W-1:0];
              rom_we_q    <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_COMMIT;
            end else if (w_beat) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_COMMIT: begin
            state_q <= ST_IDLE;
          end
          ST_TX_WAIT: begin
            if (core_ready) begin
              ext_dout_vld_q <= 1'b1;
              cnt_q          <= '0;
              state_q        <= ST_TX;
            end
          end
          ST_TX: begin
            if (w_tx_last) begin
              ext_dout_vld_q <= 1'b0;
              cnt_q          <= '0;
              state_q        <= ST_IDLE;
            end else if (w_beat) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign ext_dout         = w_sh_lo;
  assign ext_dout_vld     = ext_dout_vld_q;
  assign core_data_in     = core_data_in_q;
  assign core_data_in_vld = core_data_in_vld_q;
  assign rom_we           = rom_we_q;
  assign rom_waddr        = rom_waddr_q;
  assign rom_wdata        = rom_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_kf_pad_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_kf_pad_bridge
// Purpose  : Directed self-checking bench for kf_pad_bridge with
//            hand-computed expected values.
// Revision : 1.0
// ============================================================================
module tb_kf_pad_bridge;

  logic        clk;
  logic        rst;
  logic        ext_valid;
  logic        ext_ready;
  logic [1:0]  ext_cmd;
  logic [3:0]  ext_din;
  logic [3:0]  ext_dout;
  logic        ext_dout_vld;
  logic        ext_abort;
  logic [23:0] core_data_in;
  logic        core_data_in_vld;
  logic [23:0] core_data_out;
  logic        core_ready;
  logic        rom_we;
  logic [7:0]  rom_waddr;
  logic [15:0] rom_wdata;

  int n_chk = 0;
  int n_err = 0;
  int n_vld = 0;
  int n_we  = 0;
  int base_vld;
  int base_we;

  logic [3:0] rom_nib [6] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'h5, 4'hA};
  logic [3:0] cafe_nib [6] = '{4'h2, 4'h1, 4'hE, 4'hF, 4'hA, 4'hC};

  kf_pad_bridge u_dut (
    .clk              (clk),
    .rst              (rst),
    .ext_valid        (ext_valid),
    .ext_ready        (ext_ready),
    .ext_cmd          (ext_cmd),
    .ext_din          (ext_din),
    .ext_dout         (ext_dout),
    .ext_dout_vld     (ext_dout_vld),
    .ext_abort        (ext_abort),
    .core_data_in     (core_data_in),
    .core_data_in_vld (core_data_in_vld),
    .core_data_out    (core_data_out),
    .core_ready       (core_ready),
    .rom_we           (rom_we),
    .rom_waddr        (rom_waddr),
    .rom_wdata        (rom_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes seen at clock edges
  always @(posedge clk) begin
    if (core_data_in_vld) n_vld++;
    if (rom_we) n_we++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of host inputs, then settle just after the edge
  task automatic cyc(input logic v, input logic [1:0] c, input logic [3:0] d, input logic a);
    ext_valid = v;
    ext_cmd   = c;
    ext_din   = d;
    ext_abort = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ext_valid = 1'b0; ext_cmd = 2'b00; ext_din = 4'h0; ext_abort = 1'b0;
    core_data_out = 24'h0; core_ready = 1'b0;
    cyc(0, 2'b00, 4'h0, 0);
    cyc(1, 2'b01, 4'h0, 0);
    check("rst_ready", ext_ready, 0);
    check("rst_cdi", core_data_in, 0);
    check("rst_vld", core_data_in_vld, 0);
    check("rst_rom", {rom_we, rom_waddr, rom_wdata}, 0);
    check("rst_dout", {ext_dout_vld, ext_dout}, 0);
    rst = 1'b0;
    cyc(0, 2'b00, 4'h0, 0);
    check("post_rst_ready", ext_ready, 1);

    // WR_DATA 1..6 -> 654321
    base_vld = n_vld;
    cyc(1, 2'b01, 4'h9, 0);
    check("wd_hdr_ready", ext_ready, 1);
    for (int i = 1; i <= 6; i++) cyc(1, 2'b11, 4'(i), 0);
    check("wd_vld", core_data_in_vld, 1);
    check("wd_data", core_data_in, 24'h654321);
    check("wd_commit_ready", ext_ready, 0);
    cyc(0, 2'b00, 4'h0, 0);
    check("wd_vld_drop", core_data_in_vld, 0);
    check("wd_idle_ready", ext_ready, 1);
    check("wd_pulses", n_vld - base_vld, 1);

    // WR_ROM F,E,E,B,5,A -> A5 / BEEF
    base_we = n_we;
    cyc(1, 2'b10, 4'h0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 2'b01, rom_nib[i], 0);
    check("wr_we", rom_we, 1);
    check("wr_addr", rom_waddr, 8'hA5);
    check("wr_data", rom_wdata, 16'hBEEF);
    check("wr_cdi_kept", core_data_in, 24'h654321);
    check("wr_no_vld", core_data_in_vld, 0);
    cyc(0, 2'b00, 4'h0, 0);
    check("wr_we_drop", rom_we, 0);
    check("wr_pulses", n_we - base_we, 1);

    // RD_DATA with a 5-cycle core_ready stall
    core_data_out = 24'hABCDEF;
    core_ready = 1'b0;
    cyc(1, 2'b11, 4'h0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2'b00, 4'h0, 0);
      check("rd_wait_ready", ext_ready, 0);
      check("rd_wait_dout", {ext_dout_vld, ext_dout}, 0);
    end
    core_ready = 1'b1;
    cyc(0, 2'b00, 4'h0, 0);
    core_ready = 1'b0;
    core_data_out = 24'h123456;
    for (int i = 0; i < 6; i++) begin
      check("rd_beat", {ext_dout_vld, ext_dout}, {1'b1, 4'hF - 4'(i)});
      cyc(0, 2'b00, 4'h0, 0);
      check("rd_gap", {ext_dout_vld, ext_dout}, {1'b1, 4'hF - 4'(i)});
      cyc(1, 2'b00, 4'h0, 0);
    end
    check("rd_end_dout", {ext_dout_vld, ext_dout}, 0);
    check("rd_end_ready", ext_ready, 1);

    // RD_DATA with core_ready already high: vld rises two edges after header
    core_ready = 1'b1;
    cyc(1, 2'b11, 4'h0, 0);
    check("rd_fast_wait", ext_dout_vld, 0);
    cyc(0, 2'b00, 4'h0, 0);
    check("rd_fast_first", {ext_dout_vld, ext_dout}, {1'b1, 4'h6});
    core_ready = 1'b0;
    cyc(0, 2'b00, 4'h0, 1);
    check("rd_abort_dout", {ext_dout_vld, ext_dout}, 0);
    check("rd_abort_ready", ext_ready, 1);

    // Abort on beat 3, then abort on the final beat
    base_vld = n_vld;
    cyc(1, 2'b01, 4'h0, 0);
    cyc(1, 2'b00, 4'h7, 0);
    cyc(1, 2'b00, 4'h7, 0);
    cyc(1, 2'b00, 4'h7, 1);
    check("ab3_ready", ext_ready, 1);
    check("ab3_cdi", core_data_in, 24'h654321);
    cyc(1, 2'b01, 4'h0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 2'b00, 4'h9, 0);
    cyc(1, 2'b00, 4'h9, 1);
    check("ab6_vld", core_data_in_vld, 0);
    check("ab6_cdi", core_data_in, 24'h654321);
    check("ab6_ready", ext_ready, 1);
    check("ab_pulses", n_vld - base_vld, 0);
    cyc(1, 2'b01, 4'h0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 2'b00, cafe_nib[i], 0);
    check("ab_next_vld", core_data_in_vld, 1);
    check("ab_next_data", core_data_in, 24'hCAFE12);

    // Reset during beat 4 of WR_ROM
    cyc(0, 2'b00, 4'h0, 0);
    base_we = n_we;
    cyc(1, 2'b10, 4'h0, 0);
    cyc(1, 2'b00, 4'h1, 0);
    cyc(1, 2'b00, 4'h2, 0);
    cyc(1, 2'b00, 4'h3, 0);
    rst = 1'b1;
    cyc(1, 2'b00, 4'h4, 0);
    check("mrst_rom", {rom_we, rom_waddr, rom_wdata}, 0);
    check("mrst_cdi", core_data_in, 0);
    check("mrst_dout", {ext_dout_vld, ext_dout}, 0);
    check("mrst_ready", ext_ready, 0);
    rst = 1'b0;
    cyc(0, 2'b00, 4'h0, 0);
    check("mrst_rel_ready", ext_ready, 1);
    check("mrst_no_we", n_we - base_we, 0);

    // NOP header followed directly by WR_DATA
    base_vld = n_vld;
    base_we = n_we;
    cyc(1, 2'b00, 4'hF, 0);
    check("nop_ready", ext_ready, 1);
    check("nop_side", {core_data_in_vld, rom_we}, 0);
    cyc(1, 2'b01, 4'h0, 0);
    for (int i = 6; i >= 1; i--) cyc(1, 2'b10, 4'(i), 0);
    check("nop_wd_vld", core_data_in_vld, 1);
    check("nop_wd_data", core_data_in, 24'h123456);
    cyc(0, 2'b00, 4'h0, 0);
    check("nop_pulses", n_vld - base_vld, 1);
    check("nop_no_we", n_we - base_we, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kf_pad_bridge.md
# kf_pad_bridge

Pin-reduction bridge between the chip's pad ring and the Kalman filter core. It replaces the wide, one-pad-per-bit DATA_IN / DATA_OUT / ROM-load buses with a narrow, parametrised, framed nibble bus. The bus carries handshaken write-data, ROM-write and read-data frames, so the padframe can carry configurable-width data on PAD_W signal pads per direction.

## Interface
- PAD_W, 4, pad bus width in bits; must divide DATA_W and ADDR_W+ROM_W
- DATA_W, 24, core DATA_IN/DATA_OUT width
- ADDR_W, 8, ROM write address width
- ROM_W, 16, ROM write data width
- clk  in  1  single clock for the whole block
- rst  in  1  synchronous, active-high reset
- ext_valid  in  1  host beat valid (writes) / beat acknowledge (reads)
- ext_ready  out  1  block accepts beat this cycle
- ext_cmd  in  2  frame command, sampled only on the header beat
- ext_din  in  PAD_W  write payload beat
- ext_dout  out  PAD_W  read payload beat; 0 when ext_dout_vld=0
- ext_dout_vld  out  1  ext_dout is valid
- ext_abort  in  1  discard the current frame
- core_data_in  out  DATA_W  to core DATA_IN; holds between frames
- core_data_in_vld  out  1  one-cycle pulse on new core_data_in
- core_data_out  in  DATA_W  from core DATA_OUT
- core_ready  in  1  from core READY
- rom_we  out  1  one-cycle ROM write strobe
- rom_waddr  out  ADDR_W  ROM write address; holds
- rom_wdata  out  ROM_W  ROM write data; holds

## Operation
- Commands: 2'b00 NOP, 2'b01 WR_DATA, 2'b10 WR_ROM, 2'b11 RD_DATA.
- Beat counts: BD = DATA_W/PAD_W (6 by default); BR = (ADDR_W+ROM_W)/PAD_W (6 by default).
- States: IDLE, RX_DATA, RX_ROM, COMMIT, TX_WAIT, TX.
- A beat transfers when ext_valid && ext_ready.
- ext_ready = 1 in IDLE, RX_DATA, RX_ROM and TX. It is 0 in COMMIT and TX_WAIT, and 0 while rst is asserted.
- IDLE: the header beat is the first accepted beat. It carries only ext_cmd; ext_din is ignored.
  - NOP: stay in IDLE.
  - WR_DATA: go to RX_DATA.
  - WR_ROM: go to RX_ROM.
  - RD_DATA: go to TX_WAIT.
- RX_DATA / RX_ROM: each accepted beat shifts in LSB-first (beat 0 = bits [PAD_W-1:0]). After beat BD or BR is accepted, go to COMMIT.
- ROM payload packing is {addr, data}; address in the MSBs.
- COMMIT (exactly one cycle), then return to IDLE:
  - WR_DATA: core_data_in is updated and core_data_in_vld = 1.
  - WR_ROM: rom_waddr and rom_wdata are updated and rom_we = 1.
- TX_WAIT: hold until core_ready = 1. In that cycle, snapshot core_data_out into the shift register and go to TX.
- TX: ext_dout_vld = 1 and ext_dout = the low PAD_W bits of the shift register. Each cycle with ext_valid = 1, shift right by PAD_W. After BD acknowledged beats, return to IDLE.
- ext_abort = 1 in any state:
  - next state is IDLE and the beat counter clears;
  - no commit pulse; core_data_in and the rom_* outputs are unchanged;
  - abort has priority over beat acceptance, including the final beat.
- Reset values: all outputs 0 and state IDLE. Reset mid-frame discards the partial frame with no pulse.

## Timing
- All outputs are registered except ext_ready, which is decoded from state.
- Write frames, with the header accepted at edge T0 and back-to-back beats:
  - payload beats are accepted at edges T1 through TB;
  - the commit pulse is high in cycle TB+1, for exactly one cycle;
  - the next header can be accepted at edge TB+2.
- Host stalls (ext_valid low) extend any state indefinitely. There is no timeout.
- Read frames: if core_ready = 1 at the header, TX_WAIT lasts one cycle and ext_dout_vld rises in cycle T0+2.
- The DATA_OUT snapshot is atomic; later changes to core_data_out do not affect the frame in flight.
- ext_valid during COMMIT or TX_WAIT is ignored. ext_cmd is ignored outside the header beat.

## Structure
- Package kf_pad_pkg: command enum, state enum, and beat-count constants BD and BR as functions of the parameters.
- Package kf_pad_pkg also holds elaboration-time divisibility checks for PAD_W.
- One sub-module, kf_pad_shreg: width-parametrised shift register with load, shift-in-high and shift-out-low.
- kf_pad_shreg is shared by the RX and TX paths (max(DATA_W, ADDR_W+ROM_W) bits).
- The FSM and beat counter live in the top module.

## Test plan
- WR_DATA, payload nibbles 1,2,3,4,5,6 -> core_data_in = 24'h654321 with a single vld pulse in cycle T7; ext_ready = 0 that cycle.
- WR_ROM, nibbles F,E,E,B,5,A -> rom_waddr = 8'hA5, rom_wdata = 16'hBEEF, single rom_we pulse; core_data_in unchanged.
- RD_DATA with core_data_out = 24'hABCDEF, core_ready held low for 5 cycles, then high:
  - ext_ready = 0 throughout the wait;
  - ext_dout then gives F,E,D,C,B,A with ext_valid gaps inserted;
  - changing core_data_out mid-frame has no effect.
- Abort: WR_DATA with ext_abort on beat 3; then a second case with ext_abort coincident with beat 6 -> no vld pulse, core_data_in keeps its prior value, and the next header is accepted the following cycle.
- rst asserted during beat 4 of WR_ROM -> all outputs 0, no rom_we, ext_ready = 1 the cycle after release.
- NOP header followed by a back-to-back WR_DATA -> NOP produces no side effects and WR_DATA completes normally.
